// File: rtl/pcm_dma_if.sv
// Control, source-stream and PCM DMA bus signals of the PCM wave-RAM DMA initiator.
// master: the initiator; slave: the surrounding CDC/PCM environment.
interface pcm_dma_if #(
  parameter int LEN_W = 16
);
  logic             sub_sync;
  logic             start;
  logic             abort;
  logic [18:0]      start_addr;
  logic [LEN_W-1:0] len_words;
  logic             src_req;
  logic             src_ack;
  logic [15:0]      src_dat;
  logic [18:0]      dma_addr;
  logic [15:0]      dma_dat;
  logic             dma_ce_pcm;
  logic             dma_we;
  logic             busy;
  logic             done;

  modport master (
    input  sub_sync, start, abort, start_addr, len_words, src_ack, src_dat,
    output src_req, dma_addr, dma_dat, dma_ce_pcm, dma_we, busy, done
  );

  modport slave (
    output sub_sync, start, abort, start_addr, len_words, src_ack, src_dat,
    input  src_req, dma_addr, dma_dat, dma_ce_pcm, dma_we, busy, done
  );
endinterface

// File: rtl/pcm_dma.sv
// Copies 16-bit source words into PCM wave RAM as two byte writes (high byte first),
// pacing every write strobe on sub_sync ticks so the PCM edge-detected write completes.
module pcm_dma #(
  parameter int WR_HOLD = 2,
  parameter int WR_GAP  = 3,
  parameter int LEN_W   = 16
) (
  input logic       clk_asic,
  input logic       rst,
  pcm_dma_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_HI, S_WR_HI, S_GAP_HI, S_WR_LO, S_GAP_LO, S_FIN
  } state_t;

  localparam int TMAX = (WR_GAP > WR_HOLD) ? WR_GAP : WR_HOLD;
  localparam int TW   = $clog2(TMAX + 1);

  state_t           state_q, state_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [18:0]      addr_q, addr_d, addr_inc;
  logic [15:0]      word_q, word_d, dat_q, dat_d;
  logic             wr_q, wr_d, req_q, req_d, busy_q, busy_d, done_q, done_d;
  logic             hold_end, gap_end;

  // Byte address advances inside the 8 KB window; the upper bank bits never change.
  assign addr_inc = {addr_q[18:13], addr_q[12:0] + 13'd2};
  assign hold_end = (tick_q == TW'(WR_HOLD - 1));
  assign gap_end  = (tick_q == TW'(WR_GAP - 1));

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    word_d  = word_q;
    dat_d   = dat_q;
    wr_d    = wr_q;
    req_d   = req_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          if (bus.len_words != '0) begin
            addr_d  = bus.start_addr & ~19'd1;
            cnt_d   = bus.len_words;
            busy_d  = 1'b1;
            req_d   = 1'b1;
            state_d = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (bus.abort) begin
          req_d   = 1'b0;
          state_d = S_FIN;
        end else if (bus.src_ack) begin
          word_d  = bus.src_dat;
          req_d   = 1'b0;
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (bus.abort) begin
          state_d = S_FIN;
        end else if (bus.sub_sync) begin
          dat_d   = {8'h00, word_q[15:8]};
          wr_d    = 1'b1;
          tick_d  = '0;
          state_d = S_WR_HI;
        end
      end
      S_WR_HI, S_WR_LO: begin
        if (bus.sub_sync) begin
          if (hold_end) begin
            wr_d    = 1'b0;
            tick_d  = '0;
            state_d = (state_q == S_WR_HI) ? S_GAP_HI : S_GAP_LO;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_GAP_HI: begin
        if (bus.sub_sync) begin
          if (gap_end) begin
            addr_d  = addr_inc;
            dat_d   = {8'h00, word_q[7:0]};
            wr_d    = 1'b1;
            tick_d  = '0;
            state_d = S_WR_LO;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_GAP_LO: begin
        if (bus.sub_sync) begin
          if (gap_end) begin
            addr_d = addr_inc;
            cnt_d  = cnt_q - LEN_W'(1);
            tick_d = '0;
            // The word just finished is the only safe place to honour abort mid-transfer.
            if (bus.abort || cnt_q == LEN_W'(1)) begin
              state_d = S_FIN;
            end else begin
              req_d   = 1'b1;
              state_d = S_FETCH;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(negedge clk_asic or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      dat_q   <= '0;
      wr_q    <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      dat_q   <= dat_d;
      wr_q    <= wr_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.src_req    = req_q;
  assign bus.dma_addr   = addr_q;
  assign bus.dma_dat    = dat_q;
  assign bus.dma_ce_pcm = wr_q;
  assign bus.dma_we     = wr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_pcm_dma.sv
// Randomised bench for pcm_dma: a bus monitor records byte writes and strobe timing,
// and a transfer-level model predicts the (address, byte) write sequence.
module tb_pcm_dma;
  localparam int WR_HOLD = 2;
  localparam int WR_GAP  = 3;

  logic clk_asic = 1'b0;
  logic rst      = 1'b1;

  pcm_dma_if #(.LEN_W(16)) bus();

  pcm_dma #(.WR_HOLD(WR_HOLD), .WR_GAP(WR_GAP), .LEN_W(16)) dut (
    .clk_asic (clk_asic),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_asic = ~clk_asic;

  int          n_vec = 0;
  int          n_err = 0;
  logic [26:0] cap_q[$];
  logic [26:0] exp_q[$];
  logic [15:0] src_q[$];
  logic [18:0] exp_final;
  int          ack_delay   = 0;
  bit          spurious_en = 0;
  int          done_cnt    = 0;
  int          req_rises   = 0;
  bit          busy_seen   = 0;

  initial begin
    bus.sub_sync = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.start_addr = '0; bus.len_words = '0; bus.src_ack = 1'b0; bus.src_dat = '0;
  end

  // Pacing strobe: one cycle high every fourth clk_asic cycle.
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk_asic); #1;
      c++;
      bus.sub_sync = (c % 4 == 0);
    end
  end

  // Source side: acknowledges each request after ack_delay cycles; optional stray acks.
  initial begin
    int wc;
    bit r;
    wc = 0;
    forever begin
      @(posedge clk_asic);
      r = bus.src_req;
      #1;
      bus.src_ack = 1'b0;
      if (r) begin
        if (wc >= ack_delay && src_q.size() > 0) begin
          bus.src_ack = 1'b1;
          bus.src_dat = src_q.pop_front();
          wc = 0;
        end else begin
          wc++;
        end
      end else begin
        wc = 0;
        if (spurious_en && $urandom_range(0, 7) == 0) begin
          bus.src_ack = 1'b1;
          bus.src_dat = 16'($urandom);
        end
      end
    end
  end

  // Bus monitor: captures writes and measures strobe high/low time in sub_sync ticks.
  initial begin
    bit prev_we, prev_req, prev_done, have_prev;
    int hi_t, lo_t;
    prev_we = 0; prev_req = 0; prev_done = 0; have_prev = 0; hi_t = 0; lo_t = 0;
    forever begin
      @(posedge clk_asic);
      if (rst) begin
        prev_we = 0; prev_req = 0; prev_done = 0; have_prev = 0; hi_t = 0; lo_t = 0;
      end else begin
        if (!bus.busy) have_prev = 0;
        if (bus.busy) busy_seen = 1;
        if (bus.done) done_cnt++;
        if (bus.done && prev_done) begin
          n_err++;
          $display("FAIL done_width: done high %0d cycles in a row, required 1", 2);
        end
        if (bus.src_req && !prev_req) req_rises++;
        if (!bus.src_req && prev_req && !bus.abort) begin
          n_vec++;
          if (bus.src_ack !== 1'b1) begin
            n_err++;
            $display("FAIL src_req_hold: src_req dropped with src_ack=%b, required 1", bus.src_ack);
          end
        end
        if (bus.src_req) begin
          n_vec++;
          if (bus.dma_we !== 1'b0) begin
            n_err++;
            $display("FAIL stall_we: dma_we=%b during src_req, required 0", bus.dma_we);
          end
        end
        if (bus.dma_we && !prev_we) begin
          cap_q.push_back({bus.dma_addr, bus.dma_dat[7:0]});
          n_vec++;
          if (bus.dma_ce_pcm !== 1'b1 || bus.dma_dat[15:8] !== 8'h00) begin
            n_err++;
            $display("FAIL write_rise: ce=%b dat_hi=%h, required ce=1 dat_hi=00",
                     bus.dma_ce_pcm, bus.dma_dat[15:8]);
          end
          if (have_prev) begin
            n_vec++;
            if (lo_t < WR_GAP) begin
              n_err++;
              $display("FAIL gap_ticks: low for %0d ticks, required >= %0d", lo_t, WR_GAP);
            end
          end
          have_prev = 1;
          hi_t = 0;
        end
        if (!bus.dma_we && prev_we) begin
          n_vec++;
          if (hi_t != WR_HOLD || bus.dma_ce_pcm !== 1'b0) begin
            n_err++;
            $display("FAIL hold_ticks: high for %0d ticks ce=%b, required %0d ticks ce=0",
                     hi_t, bus.dma_ce_pcm, WR_HOLD);
          end
          lo_t = 0;
        end
        if (bus.sub_sync) begin
          if (bus.dma_we) hi_t++;
          else lo_t++;
        end
        prev_we = bus.dma_we; prev_req = bus.src_req; prev_done = bus.done;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_asic); #1;
  endtask

  function automatic logic [18:0] step(input logic [18:0] a);
    return (a & 19'h7E000) | ((a + 19'd2) & 19'h01FFF);
  endfunction

  // Model: the first nmodel words of src_q, each as high then low byte at consecutive addresses.
  task automatic prep(input logic [18:0] sa, input int nmodel);
    logic [18:0] a;
    cap_q.delete(); exp_q.delete();
    done_cnt = 0; req_rises = 0; busy_seen = 0;
    a = sa & 19'h7FFFE;
    for (int i = 0; i < nmodel; i++) begin
      exp_q.push_back({a, src_q[i][15:8]}); a = step(a);
      exp_q.push_back({a, src_q[i][7:0]});  a = step(a);
    end
    exp_final = a;
  endtask

  task automatic kick(input logic [18:0] sa, input logic [15:0] len);
    bus.start_addr = sa; bus.len_words = len; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int c;
    c = 0;
    while (done_cnt == 0 && c < budget) begin tick(); c++; end
    ok = (done_cnt != 0);
    repeat (6) tick();
  endtask

  task automatic test_reset();
    tick();
    n_vec++;
    if ({bus.src_req, bus.dma_addr, bus.dma_dat, bus.dma_ce_pcm, bus.dma_we, bus.busy, bus.done} !== '0) begin
      n_err++;
      $display("FAIL reset_held: req=%b addr=%h dat=%h ce=%b we=%b busy=%b done=%b, required all 0",
               bus.src_req, bus.dma_addr, bus.dma_dat, bus.dma_ce_pcm, bus.dma_we, bus.busy, bus.done);
    end
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    n_vec++;
    if ({bus.src_req, bus.dma_addr, bus.dma_dat, bus.dma_ce_pcm, bus.dma_we, bus.busy, bus.done} !== '0) begin
      n_err++;
      $display("FAIL reset_idle: req=%b addr=%h dat=%h busy=%b done=%b, required all 0",
               bus.src_req, bus.dma_addr, bus.dma_dat, bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    bit ok;
    ack_delay = 0; spurious_en = 0;
    src_q = '{16'hA1B2, 16'hC3D4};
    prep(19'h01000, 2);
    kick(19'h01000, 16'd2);
    wait_done(2000, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL basic_timeout: done=0, required 1"); end
    n_vec++; if (cap_q.size() != exp_q.size()) begin n_err++; $display("FAIL basic_count: %0d writes, required %0d", cap_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < cap_q.size()) begin
      n_vec++; if (cap_q[i] !== exp_q[i]) begin n_err++; $display("FAIL basic_write%0d: addr/byte %h, required %h", i, cap_q[i], exp_q[i]); end
    end
    n_vec++; if (done_cnt != 1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_done: done pulses %0d busy=%b, required 1 and 0", done_cnt, bus.busy); end
  endtask

  task automatic test_wrap();
    bit ok;
    ack_delay = 0; spurious_en = 0;
    src_q = '{16'h5566};
    prep(19'h01FFE, 1);
    kick(19'h01FFE, 16'd1);
    wait_done(2000, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_timeout: done=0, required 1"); end
    n_vec++; if (cap_q.size() != 2) begin n_err++; $display("FAIL wrap_count: %0d writes, required 2", cap_q.size()); end
    foreach (exp_q[i]) if (i < cap_q.size()) begin
      n_vec++; if (cap_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_write%0d: addr/byte %h, required %h", i, cap_q[i], exp_q[i]); end
    end
    n_vec++; if (bus.dma_addr !== exp_final) begin n_err++; $display("FAIL wrap_final_addr: %h, required %h", bus.dma_addr, exp_final); end
  endtask

  task automatic test_stall();
    bit ok;
    ack_delay = 20; spurious_en = 1;
    src_q.delete();
    for (int i = 0; i < 3; i++) src_q.push_back(16'($urandom));
    prep(19'($urandom), 3);
    kick(exp_q[0][26:8], 16'd3);
    wait_done(3000, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL stall_timeout: done=0, required 1"); end
    n_vec++; if (cap_q.size() != 6 || req_rises != 3) begin n_err++; $display("FAIL stall_count: %0d writes %0d requests, required 6 and 3", cap_q.size(), req_rises); end
    foreach (exp_q[i]) if (i < cap_q.size()) begin
      n_vec++; if (cap_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_write%0d: addr/byte %h, required %h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    logic [18:0] sa;
    for (int t = 0; t < 5; t++) begin
      n = $urandom_range(1, 4);
      ack_delay = $urandom_range(0, 6); spurious_en = 1;
      sa = 19'($urandom);
      src_q.delete();
      for (int i = 0; i < n; i++) src_q.push_back(16'($urandom));
      prep(sa, n);
      kick(sa, 16'(n));
      repeat (8) tick();
      kick(19'($urandom), 16'd7);  // start while busy must be ignored
      wait_done(3000, ok);
      n_vec++; if (!ok || done_cnt != 1) begin n_err++; $display("FAIL rand%0d_done: pulses %0d, required 1", t, done_cnt); end
      n_vec++; if (cap_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand%0d_count: %0d writes, required %0d", t, cap_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < cap_q.size()) begin
        n_vec++; if (cap_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_write%0d: addr/byte %h, required %h", t, i, cap_q[i], exp_q[i]); end
      end
      n_vec++; if (bus.dma_addr !== exp_final) begin n_err++; $display("FAIL rand%0d_final_addr: %h, required %h", t, bus.dma_addr, exp_final); end
    end
  endtask

  task automatic test_abort();
    bit ok;
    int c;
    ack_delay = 0; spurious_en = 0;
    src_q.delete();
    for (int i = 0; i < 4; i++) src_q.push_back(16'($urandom));
    prep(19'($urandom), 2);
    kick(exp_q[0][26:8], 16'd4);
    c = 0;
    while (cap_q.size() < 3 && c < 2000) begin tick(); c++; end
    bus.abort = 1'b1;
    wait_done(2000, ok);
    bus.abort = 1'b0;
    n_vec++; if (!ok || done_cnt != 1) begin n_err++; $display("FAIL abort_done: pulses %0d, required 1", done_cnt); end
    n_vec++; if (cap_q.size() != 4 || req_rises != 2) begin n_err++; $display("FAIL abort_count: %0d writes %0d requests, required 4 and 2", cap_q.size(), req_rises); end
    foreach (exp_q[i]) if (i < cap_q.size()) begin
      n_vec++; if (cap_q[i] !== exp_q[i]) begin n_err++; $display("FAIL abort_write%0d: addr/byte %h, required %h", i, cap_q[i], exp_q[i]); end
    end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: busy=%b, required 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int c;
    ack_delay = 0; spurious_en = 0;
    src_q.delete();
    for (int i = 0; i < 2; i++) src_q.push_back(16'($urandom));
    prep(19'h0ABCD, 2);
    kick(19'h0ABCD, 16'd2);
    c = 0;
    while (!(cap_q.size() == 1 && bus.dma_we == 1'b0) && c < 2000) begin tick(); c++; end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.src_req, bus.dma_addr, bus.dma_dat, bus.dma_ce_pcm, bus.dma_we, bus.busy, bus.done} !== '0) begin
      n_err++;
      $display("FAIL reset_async: req=%b addr=%h dat=%h ce=%b we=%b busy=%b, required all 0",
               bus.src_req, bus.dma_addr, bus.dma_dat, bus.dma_ce_pcm, bus.dma_we, bus.busy);
    end
    repeat (3) tick();
    rst = 1'b0;
    src_q.delete();
    repeat (3) tick();
    src_q.push_back(16'($urandom));
    prep(19'h04321, 1);
    kick(19'h04321, 16'd1);
    wait_done(2000, ok);
    n_vec++; if (!ok || cap_q.size() != 2) begin n_err++; $display("FAIL reset_rerun: done=%0d writes=%0d, required 1 and 2", done_cnt, cap_q.size()); end
    foreach (exp_q[i]) if (i < cap_q.size()) begin
      n_vec++; if (cap_q[i] !== exp_q[i]) begin n_err++; $display("FAIL reset_rerun_write%0d: addr/byte %h, required %h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_zero_len();
    src_q.delete();
    prep(19'h01234, 0);
    kick(19'h01234, 16'd0);
    repeat (12) tick();
    n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL zero_done: pulses %0d, required 1", done_cnt); end
    n_vec++; if (req_rises != 0 || cap_q.size() != 0 || busy_seen) begin n_err++; $display("FAIL zero_idle: req %0d writes %0d busy_seen %0b, required 0 0 0", req_rises, cap_q.size(), busy_seen); end
  endtask

  task automatic test_start_abort();
    src_q = '{16'h1234};
    prep(19'h00100, 0);
    bus.abort = 1'b1;
    kick(19'h00100, 16'd1);
    bus.abort = 1'b0;
    repeat (20) tick();
    n_vec++; if (done_cnt != 0 || req_rises != 0 || busy_seen) begin n_err++; $display("FAIL start_abort: done %0d req %0d busy_seen %0b, required 0 0 0", done_cnt, req_rises, busy_seen); end
    src_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_random();
    test_abort();
    test_reset_mid();
    test_zero_len();
    test_start_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
